// File: rtl/wb_stream_pkg.sv
// Shared constants, state encoding and helpers for the Wishbone stream writer.
package wb_stream_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) result++;
        return result;
    endfunction

endpackage

// File: rtl/wb_stream_flush_timer.sv
// Counts cycles spent waiting on a partial burst; expired flags a flush.
module wb_stream_flush_timer #(
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 count_en,
    input  logic [TIMEOUT_W-1:0] timeout,
    output logic                 expired
);

    logic [TIMEOUT_W-1:0] cnt;

    // A zero timeout disables flushing altogether.
    assign expired = (timeout != '0) && (cnt == timeout);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (count_en && !expired) begin
            cnt <= cnt + TIMEOUT_W'(1);
        end
    end

endmodule

// File: rtl/wb_stream_writer_ctrl.sv
// Wishbone B3 burst master draining a show-ahead FIFO into a memory ring buffer.
module wb_stream_writer_ctrl
    import wb_stream_pkg::*;
#(
    parameter int unsigned WB_AW         = 32,
    parameter int unsigned WB_DW         = 32,
    parameter int unsigned FIFO_AW       = 9,
    parameter int unsigned MAX_BURST_LEN = 256,
    parameter int unsigned TIMEOUT_W     = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic [WB_DW-1:0]     fifo_d,
    output logic                 fifo_rd,
    input  logic [FIFO_AW:0]     fifo_cnt,
    input  logic                 enable,
    input  logic                 stop,
    input  logic                 circular,
    input  logic [WB_AW-1:0]     start_adr,
    input  logic [WB_AW-1:0]     buf_size,
    input  logic [WB_AW-1:0]     burst_size,
    input  logic [TIMEOUT_W-1:0] timeout,
    output logic                 busy,
    output logic                 done,
    output logic                 wrap,
    output logic                 err,
    output logic [WB_AW-1:0]     tx_cnt
);

    localparam int unsigned SEL_W  = WB_DW / 8;
    localparam int unsigned B      = clog2(SEL_W);
    localparam int unsigned BEAT_W = clog2(MAX_BURST_LEN) + 1;

    state_t               state;
    logic [WB_AW-1:0]     base, adr, words, bl_r;
    logic                 circ_r, stop_pend, cyc;
    logic [TIMEOUT_W-1:0] tmo_r;
    logic [BEAT_W-1:0]    beats, beat_cnt;
    logic [2:0]           cti;

    logic [WB_AW-1:0]     buf_words_in, bl_in, rem, len, fifo_ext, tx_next;
    logic [BEAT_W-1:0]    go_beats;
    logic                 fill_ok, tmr_en, expired, go, last_beat, ack_ok;
    logic                 unused_ok;

    assign unused_ok = ^wbm_dat_i;

    assign wbm_adr_o = adr;
    assign wbm_dat_o = fifo_d;
    assign wbm_sel_o = '1;
    assign wbm_we_o  = cyc;
    assign wbm_cyc_o = cyc;
    assign wbm_stb_o = cyc;
    assign wbm_cti_o = cti;
    assign wbm_bte_o = BTE_LINEAR;

    // Configuration decode and burst sizing.
    always_comb begin
        buf_words_in = buf_size >> B;
        bl_in        = burst_size;
        if (burst_size == '0) begin
            bl_in = WB_AW'(1);
        end else if (burst_size > WB_AW'(MAX_BURST_LEN)) begin
            bl_in = WB_AW'(MAX_BURST_LEN);
        end
        rem       = words - tx_cnt;
        len       = (bl_r < rem) ? bl_r : rem;
        fifo_ext  = WB_AW'(fifo_cnt);
        fill_ok   = fifo_ext >= len;
        tmr_en    = (state == WAIT) && (fifo_cnt != '0) && !fill_ok;
        go        = fill_ok || (expired && (fifo_cnt != '0));
        go_beats  = fill_ok ? BEAT_W'(len) : BEAT_W'(fifo_cnt);
        last_beat = beat_cnt == (beats - BEAT_W'(1));
        tx_next   = tx_cnt + WB_AW'(1);
        ack_ok    = (state == BURST) && cyc && wbm_ack_i && !wbm_err_i;
    end

    assign fifo_rd = ack_ok;

    wb_stream_flush_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_flush_timer (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .clear    (state != WAIT),
        .count_en (tmr_en),
        .timeout  (tmo_r),
        .expired  (expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            base      <= '0;
            adr       <= '0;
            words     <= '0;
            bl_r      <= '0;
            circ_r    <= 1'b0;
            stop_pend <= 1'b0;
            cyc       <= 1'b0;
            tmo_r     <= '0;
            beats     <= '0;
            beat_cnt  <= '0;
            cti       <= CTI_CLASSIC;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
            tx_cnt    <= '0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && (buf_words_in != '0)) begin
                        base      <= start_adr;
                        adr       <= start_adr;
                        words     <= buf_words_in;
                        bl_r      <= bl_in;
                        circ_r    <= circular;
                        tmo_r     <= timeout;
                        tx_cnt    <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        stop_pend <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (go) begin
                        beats    <= go_beats;
                        beat_cnt <= '0;
                        cyc      <= 1'b1;
                        cti      <= (go_beats == BEAT_W'(1)) ? CTI_CLASSIC : CTI_INCR;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (stop) stop_pend <= 1'b1;
                    if (cyc && wbm_err_i) begin
                        cyc   <= 1'b0;
                        cti   <= CTI_CLASSIC;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (ack_ok) begin
                        tx_cnt   <= tx_next;
                        adr      <= adr + WB_AW'(SEL_W);
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        if (last_beat) begin
                            cyc       <= 1'b0;
                            cti       <= CTI_CLASSIC;
                            stop_pend <= 1'b0;
                            if ((tx_next == words) && !circ_r) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                // Ring end: restart at the base address.
                                if (tx_next == words) begin
                                    tx_cnt <= '0;
                                    adr    <= base;
                                    wrap   <= 1'b1;
                                end
                                if (stop || stop_pend) begin
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    state <= IDLE;
                                end else begin
                                    state <= WAIT;
                                end
                            end
                        end else if ((beat_cnt + BEAT_W'(2)) == beats) begin
                            cti <= CTI_EOB;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
